// File: rtl/memory_stage_lsu.sv
// MEM stage / load-store unit: sub-word access, req/ack DMEM handshake.
// Optional MISALIGN_TRAP_EN: trap on unaligned access instead of aligning down.
module memory_stage_lsu #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic                DMEM_req_o,
  output logic                DMEM_we_o,
  output logic [ADDR_W-1:0]   DMEM_addr_o,
  output logic [DATA_W-1:0]   DMEM_wdata_o,
  output logic [DATA_W/8-1:0] DMEM_be_o,
  input  logic [DATA_W-1:0]   DMEM_rdata_i,
  input  logic                DMEM_ack_i,
  input  logic [DATA_W-1:0]   PIP_alu_result_i,
  input  logic [DATA_W-1:0]   PIP_second_operand_i,
  input  logic [4:0]          PIP_rd_i,
  input  logic [2:0]          PIP_funct3_i,
  input  logic                PIP_read_mem_i,
  input  logic                PIP_write_mem_i,
  input  logic                PIP_use_mem_i,
  input  logic                PIP_write_reg_i,
  input  logic                PIP_TRAP_i,
  output logic                stall_o,
  output logic                PIP_use_mem_o,
  output logic                PIP_write_reg_o,
  output logic [4:0]          PIP_rd_o,
  output logic [DATA_W-1:0]   PIP_alu_result_o,
  output logic [DATA_W-1:0]   PIP_load_data_o,
  output logic                PIP_TRAP_o
);

  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            use_mem_q, write_reg_q, trap_q;
  logic [4:0]      rd_q;
  logic [DATA_W-1:0] alu_q, ldata_q;

  logic [1:0]        size;
  logic              uns, mem, legal, mis, ill, op;
  logic              timeout, trap_any;
  logic [DATA_W-1:0] amask, eff_addr;
  logic [LB-1:0]     lane;
  logic [DATA_W-1:0] sh, lmask, ext;
  logic              sbit;
  logic [7:0]        m8;

  assign size = PIP_funct3_i[1:0];
  assign uns  = PIP_funct3_i[2];
  assign mem  = PIP_read_mem_i | PIP_write_mem_i;

  // Size-dependent constants: alignment mask, byte mask, load field mask
  always_comb begin
    amask = '0;
    m8    = 8'h00;
    lmask = '1;
    sbit  = 1'b0;
    unique case (size)
      2'd0: begin
        amask = DATA_W'(0); m8 = 8'h01;
        lmask = DATA_W'(64'hFF); sbit = sh[7];
      end
      2'd1: begin
        amask = DATA_W'(1); m8 = 8'h03;
        lmask = DATA_W'(64'hFFFF); sbit = sh[15];
      end
      2'd2: begin
        amask = DATA_W'(3); m8 = 8'h0F;
        lmask = DATA_W'(64'hFFFF_FFFF); sbit = sh[31];
      end
      default: begin
        amask = DATA_W'(7); m8 = 8'hFF;
        lmask = '1; sbit = 1'b0;
      end
    endcase
  end

  // Legal access sizes; doubleword forms exist only on 64-bit datapaths
  always_comb begin
    legal = 1'b0;
    unique case (PIP_funct3_i)
      3'b000, 3'b001, 3'b010,
      3'b100, 3'b101: legal = 1'b1;
      3'b011, 3'b110: legal = (DATA_W == 64);
      default:        legal = 1'b0;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign mis = mem & ~PIP_TRAP_i & legal
             & (|(PIP_alu_result_i & amask));
  assign eff_addr = PIP_alu_result_i;
`else
  assign mis = 1'b0;
  assign eff_addr = PIP_alu_result_i & ~amask;
`endif

  assign ill  = mem & ~PIP_TRAP_i & ~legal;
  assign op   = mem & ~PIP_TRAP_i & legal & ~mis;
  assign lane = eff_addr[LB-1:0];

  assign timeout = (state_q == S_WAIT)
                 & (cnt_q == CW'(MAX_WAIT - 1))
                 & ~DMEM_ack_i;
  assign trap_any = PIP_TRAP_i | ill | mis | timeout;

  assign DMEM_req_o  = op & reset_n;
  assign stall_o     = op & ~DMEM_ack_i & ~timeout & reset_n;
  assign DMEM_we_o   = PIP_write_mem_i;
  assign DMEM_addr_o = ADDR_W'(eff_addr);
  assign DMEM_be_o   = NB'(m8) << lane;

  // Store data replicated across every lane of the bus
  always_comb begin
    DMEM_wdata_o = PIP_second_operand_i;
    unique case (size)
      2'd0: DMEM_wdata_o = {NB{PIP_second_operand_i[7:0]}};
      2'd1: DMEM_wdata_o = {(NB/2){PIP_second_operand_i[15:0]}};
      2'd2: DMEM_wdata_o = {(DATA_W/32){PIP_second_operand_i[31:0]}};
      default: DMEM_wdata_o = PIP_second_operand_i;
    endcase
  end

  // Lane steering and sign/zero extension of load data
  always_comb begin
    sh  = DMEM_rdata_i >> {lane, 3'b000};
    ext = (sh & lmask) | ((sbit & ~uns) ? ~lmask : '0);
  end

  // Wait-state FSM next state and counter
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      S_IDLE: if (op & ~DMEM_ack_i) state_d = S_WAIT;
      S_WAIT: begin
        if (DMEM_ack_i | timeout) state_d = S_IDLE;
        else                      cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // MEM/WB pipeline register: bubble on stall, trap squashes write
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      use_mem_q   <= 1'b0;
      write_reg_q <= 1'b0;
      rd_q        <= '0;
      alu_q       <= '0;
      ldata_q     <= '0;
      trap_q      <= 1'b0;
    end else if (stall_o) begin
      use_mem_q   <= 1'b0;
      write_reg_q <= 1'b0;
      rd_q        <= '0;
      trap_q      <= 1'b0;
    end else begin
      use_mem_q   <= PIP_use_mem_i;
      write_reg_q <= PIP_write_reg_i & ~trap_any;
      rd_q        <= PIP_rd_i;
      alu_q       <= PIP_alu_result_i;
      ldata_q     <= ext;
      trap_q      <= trap_any;
    end
  end

  assign PIP_use_mem_o    = use_mem_q;
  assign PIP_write_reg_o  = write_reg_q;
  assign PIP_rd_o         = rd_q;
  assign PIP_alu_result_o = alu_q;
  assign PIP_load_data_o  = ldata_q;
  assign PIP_TRAP_o       = trap_q;

endmodule

// File: tb/tb_memory_stage_lsu.sv
// Directed bench for memory_stage_lsu (DATA_W=32, MAX_WAIT=15).
// Honours MISALIGN_TRAP_EN for the misaligned-load step.
module tb_memory_stage_lsu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req, we, ack;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic [31:0] alu, opnd;
  logic [4:0]  rd;
  logic [2:0]  f3;
  logic        rmem, wmem, umem, wreg, trap_i;
  logic        stall, umem_o, wreg_o, trap_o;
  logic [4:0]  rd_o;
  logic [31:0] alu_o, ld_o;

  int vectors = 0;
  int miscompares = 0;
  int n;

  always #5 clk = ~clk;

  memory_stage_lsu #(.DATA_W(32), .ADDR_W(32), .MAX_WAIT(15)) dut (
    .clk(clk), .reset_n(reset_n),
    .DMEM_req_o(req), .DMEM_we_o(we), .DMEM_addr_o(addr),
    .DMEM_wdata_o(wdata), .DMEM_be_o(be),
    .DMEM_rdata_i(rdata), .DMEM_ack_i(ack),
    .PIP_alu_result_i(alu), .PIP_second_operand_i(opnd),
    .PIP_rd_i(rd), .PIP_funct3_i(f3),
    .PIP_read_mem_i(rmem), .PIP_write_mem_i(wmem),
    .PIP_use_mem_i(umem), .PIP_write_reg_i(wreg),
    .PIP_TRAP_i(trap_i), .stall_o(stall),
    .PIP_use_mem_o(umem_o), .PIP_write_reg_o(wreg_o),
    .PIP_rd_o(rd_o), .PIP_alu_result_o(alu_o),
    .PIP_load_data_o(ld_o), .PIP_TRAP_o(trap_o)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nop();
    alu = 32'h0; opnd = 32'h0; rd = 5'd0; f3 = 3'b000;
    rmem = 1'b0; wmem = 1'b0; umem = 1'b0; wreg = 1'b0;
    trap_i = 1'b0; ack = 1'b0; rdata = 32'h0;
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] f,
                      input logic [4:0] r, input logic [31:0] d,
                      input logic k);
    nop();
    alu = a; f3 = f; rd = r; rdata = d; ack = k;
    rmem = 1'b1; umem = 1'b1; wreg = 1'b1;
  endtask

  task automatic store(input logic [31:0] a, input logic [2:0] f,
                       input logic [31:0] d, input logic k);
    nop();
    alu = a; f3 = f; opnd = d; ack = k; wmem = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nop();
    reset_n = 1'b0;
    load(32'h100, 3'b010, 5'd3, 32'h0, 1'b0);
    #1;
    chk("rst_req", req, 0);
    chk("rst_stall", stall, 0);
    step(); step();
    chk("rst_trap", trap_o, 0);
    chk("rst_wreg", wreg_o, 0);
    chk("rst_rd", rd_o, 0);
    nop();
    reset_n = 1'b1;
    step();

    // 1: SW zero-wait
    store(32'h100, 3'b010, 32'hDEADBEEF, 1'b1);
    #1;
    chk("sw_req", req, 1);
    chk("sw_we", we, 1);
    chk("sw_be", be, 4'b1111);
    chk("sw_wdata", wdata, 32'hDEADBEEF);
    chk("sw_stall", stall, 0);
    step();
    chk("sw_wreg", wreg_o, 0);
    chk("sw_trap", trap_o, 0);

    // 2: LB with 3 wait states
    load(32'h103, 3'b000, 5'd5, 32'h80123456, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lb_stall", stall, 1);
      step();
      chk("lb_bub_wreg", wreg_o, 0);
      chk("lb_bub_rd", rd_o, 0);
    end
    ack = 1'b1;
    #1;
    chk("lb_ack_stall", stall, 0);
    chk("lb_ack_req", req, 1);
    step();
    chk("lb_data", ld_o, 32'hFFFFFF80);
    chk("lb_wreg", wreg_o, 1);
    chk("lb_rd", rd_o, 5);
    chk("lb_umem", umem_o, 1);

    // 3: SB lane 2, LHU/LH/LBU extension
    store(32'h102, 3'b000, 32'h000000A5, 1'b1);
    #1;
    chk("sb_be", be, 4'b0100);
    chk("sb_wdata", wdata, 32'hA5A5A5A5);
    step();
    store(32'h102, 3'b001, 32'h00001234, 1'b1);
    #1;
    chk("sh_be", be, 4'b1100);
    chk("sh_wdata", wdata, 32'h12341234);
    step();
    load(32'h102, 3'b101, 5'd6, 32'hBEEF1234, 1'b1);
    #1;
    chk("lhu_stall", stall, 0);
    step();
    chk("lhu_data", ld_o, 32'h0000BEEF);
    load(32'h102, 3'b001, 5'd6, 32'hBEEF1234, 1'b1);
    step();
    chk("lh_data", ld_o, 32'hFFFFBEEF);
    load(32'h101, 3'b100, 5'd6, 32'h0000C300, 1'b1);
    step();
    chk("lbu_data", ld_o, 32'h000000C3);

    // 4: timeout
    load(32'h200, 3'b010, 5'd7, 32'h0, 1'b0);
    #1;
    n = 0;
    while (stall === 1'b1 && n < 40) begin
      n++;
      step();
      #1;
    end
    chk("to_stall_cycles", n, 15);
    step();
    chk("to_trap", trap_o, 1);
    chk("to_wreg", wreg_o, 0);
    load(32'h204, 3'b010, 5'd8, 32'h55AA55AA, 1'b0);
    #1;
    chk("to_idle_stall", stall, 1);
    step();
    ack = 1'b1;
    step();
    chk("to_next_data", ld_o, 32'h55AA55AA);
    chk("to_next_trap", trap_o, 0);

    // 5: misaligned LW
    load(32'h101, 3'b010, 5'd9, 32'h11223344, 1'b1);
    #1;
`ifdef MISALIGN_TRAP_EN
    chk("mis_req", req, 0);
    chk("mis_stall", stall, 0);
    step();
    chk("mis_trap", trap_o, 1);
    chk("mis_wreg", wreg_o, 0);
`else
    chk("mis_req", req, 1);
    chk("mis_addr", addr, 32'h100);
    step();
    chk("mis_data", ld_o, 32'h11223344);
    chk("mis_trap", trap_o, 0);
`endif

    // 6: reset during WAIT
    load(32'h300, 3'b010, 5'd10, 32'h0, 1'b0);
    step(); step();
    #1;
    chk("rw_stall_pre", stall, 1);
    reset_n = 1'b0;
    #1;
    chk("rw_req", req, 0);
    chk("rw_stall", stall, 0);
    step();
    chk("rw_trap", trap_o, 0);
    chk("rw_alu", alu_o, 0);
    chk("rw_ld", ld_o, 0);
    chk("rw_umem", umem_o, 0);
    nop();
    reset_n = 1'b1;
    step();

    // illegal funct3 111 and 011 (32-bit)
    load(32'h100, 3'b111, 5'd11, 32'h0, 1'b1);
    #1;
    chk("ill7_req", req, 0);
    step();
    chk("ill7_trap", trap_o, 1);
    chk("ill7_wreg", wreg_o, 0);
    load(32'h100, 3'b011, 5'd11, 32'h0, 1'b1);
    #1;
    chk("ill3_req", req, 0);
    step();
    chk("ill3_trap", trap_o, 1);

    // upstream trap suppresses request
    load(32'h100, 3'b010, 5'd12, 32'h0, 1'b1);
    trap_i = 1'b1;
    #1;
    chk("tin_req", req, 0);
    step();
    chk("tin_trap", trap_o, 1);
    chk("tin_wreg", wreg_o, 0);

    // non-memory pass-through
    nop();
    alu = 32'h1234; rd = 5'd9; wreg = 1'b1; f3 = 3'b111;
    #1;
    chk("alu_req", req, 0);
    step();
    chk("alu_res", alu_o, 32'h1234);
    chk("alu_wreg", wreg_o, 1);
    chk("alu_rd", rd_o, 9);
    chk("alu_trap", trap_o, 0);

    nop();
    step();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
